// File: rtl/tb_result_scoreboard_if.sv
// Checker-result channel bundle: one valid/pass strobe pair per channel.
interface tb_result_scoreboard_if #(
   parameter int NUM_CH = 4
) ();
   logic [NUM_CH-1:0] chk_valid;
   logic [NUM_CH-1:0] chk_pass;

   modport master (output chk_valid, output chk_pass);
   modport slave  (input  chk_valid, input  chk_pass);
endinterface

// File: rtl/tb_result_scoreboard.sv
// Multi-channel pass/fail scoreboard with watchdog and
// sequential pass-ratio divider producing a final verdict.
module tb_result_scoreboard #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 10000,
   parameter int TO_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   tb_result_scoreboard_if.slave chk,
   input  logic                 end_of_test,
   output logic [CNT_W-1:0]     pass_cnt,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic [CNT_W-1:0]     total_cnt,
   output logic [NUM_CH-1:0]    ch_fail_mask,
   output logic [6:0]           ratio_pct,
   output logic                 busy,
   output logic                 done,
   output logic                 verdict_pass,
   output logic                 timeout,
   output logic                 saturated
);
   localparam int DW = CNT_W + 7;
   localparam int BW = $clog2(DW + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state;
   logic [NUM_CH-1:0] pv;
   logic [NUM_CH-1:0] fv;
   logic [4:0]        np;
   logic [4:0]        nf;
   logic [4:0]        nt;
   logic [CNT_W:0]    p_sum;
   logic [CNT_W:0]    f_sum;
   logic [CNT_W:0]    t_sum;
   logic              any_valid;
   logic              wd_fire;
   logic [TO_W-1:0]   wd;
   logic [DW-1:0]     quo;
   logic [CNT_W-1:0]  rem;
   logic [BW-1:0]     dcnt;
   logic [CNT_W:0]    rem_sh;
   logic [CNT_W:0]    rem_sub;
   logic              rem_ge;

   assign pv = chk.chk_valid & chk.chk_pass;
   assign fv = chk.chk_valid & ~chk.chk_pass;
   assign any_valid = |chk.chk_valid;

   always_comb begin
      np = '0;
      nf = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         np = np + {4'd0, pv[i]};
         nf = nf + {4'd0, fv[i]};
      end
   end

   assign nt = np + nf;
   assign p_sum = {1'b0, pass_cnt}  + (CNT_W+1)'(np);
   assign f_sum = {1'b0, fail_cnt}  + (CNT_W+1)'(nf);
   assign t_sum = {1'b0, total_cnt} + (CNT_W+1)'(nt);

   // Last idle cycle before the count would reach TIMEOUT.
   assign wd_fire = (TIMEOUT != 0) && !any_valid &&
                    (wd == TO_W'(TIMEOUT - 1));

   assign rem_sh  = {rem, quo[DW-1]};
   assign rem_ge  = rem_sh >= {1'b0, total_cnt};
   assign rem_sub = rem_sh - {1'b0, total_cnt};

   assign busy = (state == S_RUN) || (state == S_CALC);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         total_cnt    <= '0;
         ch_fail_mask <= '0;
         ratio_pct    <= '0;
         verdict_pass <= 1'b0;
         timeout      <= 1'b0;
         saturated    <= 1'b0;
         wd           <= '0;
         quo          <= '0;
         rem          <= '0;
         dcnt         <= '0;
      end else if (start) begin
         state        <= S_RUN;
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         total_cnt    <= '0;
         ch_fail_mask <= '0;
         ratio_pct    <= '0;
         verdict_pass <= 1'b0;
         timeout      <= 1'b0;
         saturated    <= 1'b0;
         wd           <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (end_of_test || wd_fire) begin
                  state   <= S_CALC;
                  timeout <= timeout | wd_fire;
                  quo     <= DW'(pass_cnt) * DW'(7'd100);
                  rem     <= '0;
                  dcnt    <= '0;
               end else begin
                  pass_cnt  <= p_sum[CNT_W] ? '1 : p_sum[CNT_W-1:0];
                  fail_cnt  <= f_sum[CNT_W] ? '1 : f_sum[CNT_W-1:0];
                  total_cnt <= t_sum[CNT_W] ? '1 : t_sum[CNT_W-1:0];
                  saturated <= saturated | p_sum[CNT_W] |
                               f_sum[CNT_W] | t_sum[CNT_W];
                  ch_fail_mask <= ch_fail_mask | fv;
                  wd <= any_valid ? '0 : wd + 1'b1;
               end
            end
            S_CALC: begin
               if (total_cnt == '0 || dcnt == BW'(DW)) begin
                  state        <= S_DONE;
                  ratio_pct    <= (total_cnt == '0) ? 7'd0 : quo[6:0];
                  verdict_pass <= (total_cnt != '0) && (fail_cnt == '0) &&
                                  !timeout && !saturated;
               end else begin
                  rem  <= rem_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                  quo  <= {quo[DW-2:0], rem_ge};
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tb_result_scoreboard.sv
// Scoreboard-driven bench: two scoreboard instances (wide counters with
// a short watchdog, narrow counters without watchdog).
module tb_tb_result_scoreboard;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic a_start = 0, a_eot = 0, b_start = 0, b_eot = 0;
   tb_result_scoreboard_if #(.NUM_CH(4)) a_if ();
   tb_result_scoreboard_if #(.NUM_CH(4)) b_if ();

   logic [15:0] a_pass, a_fail, a_total;
   logic [3:0]  a_mask;
   logic [6:0]  a_ratio;
   logic        a_busy, a_done, a_verdict, a_tmo, a_sat;
   logic [3:0]  b_pass, b_fail, b_total;
   logic [3:0]  b_mask;
   logic [6:0]  b_ratio;
   logic        b_busy, b_done, b_verdict, b_tmo, b_sat;

   tb_result_scoreboard #(.NUM_CH(4), .CNT_W(16), .TIMEOUT(20), .TO_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .chk(a_if.slave),
      .end_of_test(a_eot), .pass_cnt(a_pass), .fail_cnt(a_fail),
      .total_cnt(a_total), .ch_fail_mask(a_mask), .ratio_pct(a_ratio),
      .busy(a_busy), .done(a_done), .verdict_pass(a_verdict),
      .timeout(a_tmo), .saturated(a_sat));

   tb_result_scoreboard #(.NUM_CH(4), .CNT_W(4), .TIMEOUT(0), .TO_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .chk(b_if.slave),
      .end_of_test(b_eot), .pass_cnt(b_pass), .fail_cnt(b_fail),
      .total_cnt(b_total), .ch_fail_mask(b_mask), .ratio_pct(b_ratio),
      .busy(b_busy), .done(b_done), .verdict_pass(b_verdict),
      .timeout(b_tmo), .saturated(b_sat));

   typedef struct {
      int pass, fail, total, mask, ratio, verdict, tmo, sat;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int failures = 0;
   int mp, mf, mt, mm, ms, mto;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      mp = 0; mf = 0; mt = 0; mm = 0; ms = 0; mto = 0;
   endtask

   task automatic pulse_start(bit sel);
      if (sel) b_start = 1; else a_start = 1;
      cyc();
      a_start = 0; b_start = 0;
      model_clear();
   endtask

   task automatic drive(bit sel, logic [3:0] v, logic [3:0] p);
      int maxv;
      maxv = sel ? 15 : 65535;
      if (sel) begin b_if.chk_valid = v; b_if.chk_pass = p; end
      else     begin a_if.chk_valid = v; a_if.chk_pass = p; end
      cyc();
      a_if.chk_valid = 0; a_if.chk_pass = 0;
      b_if.chk_valid = 0; b_if.chk_pass = 0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            if (p[i]) mp++;
            else begin mf++; mm |= (1 << i); end
            mt++;
         end
      end
      if (mp > maxv) begin mp = maxv; ms = 1; end
      if (mf > maxv) begin mf = maxv; ms = 1; end
      if (mt > maxv) begin mt = maxv; ms = 1; end
   endtask

   task automatic push_exp();
      exp_t e;
      e.pass = mp; e.fail = mf; e.total = mt; e.mask = mm;
      e.ratio = (mt != 0) ? (mp * 100) / mt : 0;
      e.verdict = (mt != 0 && mf == 0 && mto == 0 && ms == 0) ? 1 : 0;
      e.tmo = mto; e.sat = ms;
      q.push_back(e);
   endtask

   task automatic compare(bit sel, string tag);
      exp_t e;
      if (q.size() == 0) begin
         check({tag, "_q_empty"}, 64'd0, 64'd1);
         return;
      end
      e = q.pop_front();
      if (sel) begin
         check({tag, "_pass"},    64'(b_pass),    64'(e.pass));
         check({tag, "_fail"},    64'(b_fail),    64'(e.fail));
         check({tag, "_total"},   64'(b_total),   64'(e.total));
         check({tag, "_mask"},    64'(b_mask),    64'(e.mask));
         check({tag, "_ratio"},   64'(b_ratio),   64'(e.ratio));
         check({tag, "_verdict"}, 64'(b_verdict), 64'(e.verdict));
         check({tag, "_tmo"},     64'(b_tmo),     64'(e.tmo));
         check({tag, "_sat"},     64'(b_sat),     64'(e.sat));
      end else begin
         check({tag, "_pass"},    64'(a_pass),    64'(e.pass));
         check({tag, "_fail"},    64'(a_fail),    64'(e.fail));
         check({tag, "_total"},   64'(a_total),   64'(e.total));
         check({tag, "_mask"},    64'(a_mask),    64'(e.mask));
         check({tag, "_ratio"},   64'(a_ratio),   64'(e.ratio));
         check({tag, "_verdict"}, 64'(a_verdict), 64'(e.verdict));
         check({tag, "_tmo"},     64'(a_tmo),     64'(e.tmo));
         check({tag, "_sat"},     64'(a_sat),     64'(e.sat));
      end
   endtask

   task automatic wait_done(bit sel, output int n);
      n = 0;
      while (!(sel ? b_done : a_done) && n < 200) begin
         cyc();
         n++;
      end
   endtask

   task automatic eot_finish(bit sel, int lat, string tag);
      int n;
      push_exp();
      if (sel) b_eot = 1; else a_eot = 1;
      cyc();
      a_eot = 0; b_eot = 0;
      wait_done(sel, n);
      check({tag, "_latency"}, 64'(n), 64'(lat));
      compare(sel, tag);
   endtask

   initial begin
      int n;
      a_if.chk_valid = 0; a_if.chk_pass = 0;
      b_if.chk_valid = 0; b_if.chk_pass = 0;
      #12;
      check("reset_a", {a_pass, a_fail, a_total, a_mask, a_ratio,
                        a_busy, a_done, a_verdict, a_tmo, a_sat}, 64'd0);
      check("reset_b", 64'({b_pass, b_fail, b_total, b_mask, b_ratio,
                        b_busy, b_done, b_verdict, b_tmo, b_sat}), 64'd0);
      rst_n = 1;
      cyc();

      // All-pass run on one channel
      pulse_start(0);
      check("start_busy", 64'(a_busy), 64'd1);
      for (int i = 0; i < 10; i++) drive(0, 4'b0001, 4'b0001);
      eot_finish(0, 24, "allpass");

      // Mixed result; checks on the end_of_test cycle must be ignored
      pulse_start(0);
      drive(0, 4'b1111, 4'b1010);
      push_exp();
      a_if.chk_valid = 4'b1111; a_if.chk_pass = 4'b1111; a_eot = 1;
      cyc();
      a_if.chk_valid = 0; a_if.chk_pass = 0; a_eot = 0;
      wait_done(0, n);
      check("mixed_latency", 64'(n), 64'd24);
      compare(0, "mixed");

      pulse_start(0);
      for (int i = 0; i < 3; i++) drive(0, 4'b0001, 4'b0001);
      drive(0, 4'b0010, 4'b0000);
      eot_finish(0, 24, "r75");

      pulse_start(0);
      for (int i = 0; i < 2; i++) drive(0, 4'b0100, 4'b0100);
      drive(0, 4'b1000, 4'b0000);
      eot_finish(0, 24, "r66");

      // Watchdog
      pulse_start(0);
      for (int i = 0; i < 5; i++) drive(0, 4'b0001, 4'b0001);
      mto = 1;
      push_exp();
      n = 0;
      while (!a_tmo && n < 100) begin cyc(); n++; end
      check("wd_cycles", 64'(n), 64'd20);
      wait_done(0, n);
      check("wd_done_seen", 64'(a_done), 64'd1);
      compare(0, "wd");

      // start beats end_of_test; then an empty run
      pulse_start(0);
      drive(0, 4'b0011, 4'b0011);
      a_start = 1; a_eot = 1;
      cyc();
      a_start = 0; a_eot = 0;
      model_clear();
      check("startwin_busy", 64'(a_busy), 64'd1);
      check("startwin_pass", 64'(a_pass), 64'd0);
      eot_finish(0, 1, "empty");

      // Narrow counters saturate
      pulse_start(1);
      for (int i = 0; i < 20; i++) drive(1, 4'b0001, 4'b0001);
      eot_finish(1, 12, "sat");

      // Reset during CALC
      pulse_start(1);
      for (int i = 0; i < 3; i++) drive(1, 4'b0001, 4'b0001);
      b_eot = 1;
      cyc();
      b_eot = 0;
      for (int i = 0; i < 4; i++) cyc();
      check("calc_busy", 64'(b_busy), 64'd1);
      #2 rst_n = 0;
      #1;
      check("rst_calc_b", 64'({b_pass, b_fail, b_total, b_mask, b_ratio,
                           b_busy, b_done, b_verdict, b_tmo, b_sat}), 64'd0);
      cyc();
      rst_n = 1;
      cyc();
      check("idle_after_rst", 64'({b_busy, b_done}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
